// File: rtl/tt_lut_seq.sv
// Reprogrammable 2^N_IN-row truth-table evaluator with a serially loaded, double-buffered table.
// Define TT_LOAD_PARITY_EN to require an even-parity bit after each table load.
module tt_lut_seq #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_bit,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    output logic            cfg_done,
    output logic            cfg_err,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_valid,
    output logic            out,
    output logic            out_valid,
    output logic            busy
);

    localparam int TABLE_W = 1 << N_IN;

`ifdef TT_LOAD_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PARITY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD} state_t;
`endif

    state_t             state_q;
    logic [TABLE_W-1:0] act_q;
    logic [TABLE_W-1:0] shd_q;
    logic [TABLE_W-1:0] shd_d;
    logic [N_IN:0]      cnt_q;
    logic               out_q;
    logic               out_valid_q;
    logic               done_q;
    logic               ready_q;
    logic               busy_q;
    logic               last_row;

    // Shadow contents including the bit being accepted this cycle, so the final
    // table bit can be committed on the same edge that accepts it.
    always_comb begin
        shd_d = shd_q;
        shd_d[cnt_q[N_IN-1:0]] = cfg_bit;
    end

    assign last_row = (cnt_q[N_IN-1:0] == {N_IN{1'b1}});

`ifdef TT_LOAD_PARITY_EN
    logic err_q;
    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            act_q       <= '0;
            shd_q       <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef TT_LOAD_PARITY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            // Evaluation uses the table as it was before this edge.
            out_q       <= act_q[in_vec];
            out_valid_q <= in_valid;
            done_q      <= 1'b0;
`ifdef TT_LOAD_PARITY_EN
            err_q       <= 1'b0;
`endif
            if (cfg_start) begin
                state_q <= S_LOAD;
                cnt_q   <= '0;
                shd_q   <= '0;
                ready_q <= 1'b1;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    S_LOAD: begin
                        if (cfg_valid) begin
                            shd_q <= shd_d;
                            cnt_q <= cnt_q + 1'b1;
                            if (last_row) begin
`ifdef TT_LOAD_PARITY_EN
                                state_q <= S_PARITY;
`else
                                act_q   <= shd_d;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef TT_LOAD_PARITY_EN
                    S_PARITY: begin
                        if (cfg_valid) begin
                            if ((^shd_q ^ cfg_bit) == 1'b0) begin
                                act_q  <= shd_q;
                                done_q <= 1'b1;
                            end else begin
                                err_q  <= 1'b1;
                            end
                            state_q <= S_IDLE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cfg_done  = done_q;
    assign cfg_ready = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tt_lut_seq.sv
// Directed bench for tt_lut_seq (N_IN=4): reset state, loads, live reload, restart and reset mid-load.
module tb_tt_lut_seq;
    localparam int N_IN = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_start = 1'b0;
    logic            cfg_bit = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic            cfg_done;
    logic            cfg_err;
    logic [N_IN-1:0] in_vec = '0;
    logic            in_valid = 1'b0;
    logic            out;
    logic            out_valid;
    logic            busy;

    int errors = 0;
    int checks = 0;

    tt_lut_seq #(.N_IN(N_IN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, out, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_ready"}, cfg_ready, 1'b0);
        check({tag, "_done"}, cfg_done, 1'b0);
        check({tag, "_err"}, cfg_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("start_ready", cfg_ready, 1'b1);
        check("start_busy", busy, 1'b1);
    endtask

    // Shifts 16 table bits, row 0 first; optional 3-cycle stall before bit stall_at.
    task automatic send_bits(input logic [15:0] v, input int stall_at);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                cfg_valid = 1'b0;
                repeat (3) begin
                    tick();
                    check("stall_ready", cfg_ready, 1'b1);
                end
            end
            cfg_valid = 1'b1;
            cfg_bit   = v[i];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    // Parity bit (macro builds only), then confirm the one-cycle done pulse.
    task automatic finish_load(input logic par, input string tag);
`ifdef TT_LOAD_PARITY_EN
        check({tag, "_parity_ready"}, cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        cfg_bit   = par;
        tick();
        cfg_valid = 1'b0;
`else
        if (par) cfg_bit = 1'b0;
`endif
        check({tag, "_done"}, cfg_done, 1'b1);
        check({tag, "_err"}, cfg_err, 1'b0);
        check({tag, "_ready_low"}, cfg_ready, 1'b0);
        tick();
        check({tag, "_done_pulse"}, cfg_done, 1'b0);
        check({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic eval(input logic [3:0] v, input logic exp, input string tag);
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        check(tag, out, exp);
        check({tag, "_valid"}, out_valid, 1'b1);
    endtask

    initial begin
        // Reset state
        in_valid = 1'b1;
        in_vec   = 4'd5;
        repeat (2) tick();
        check_all_zero("reset");
        #3 rst_n = 1'b1;

        for (int r = 0; r < 16; r++) eval(4'(r), 1'b0, $sformatf("blank_row%0d", r));
        in_valid = 1'b0;
        tick();
        check("out_valid_drop", out_valid, 1'b0);

        // cfg_valid in IDLE has no effect
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        repeat (3) tick();
        cfg_valid = 1'b0;
        check("idle_ready", cfg_ready, 1'b0);
        check("idle_busy", busy, 1'b0);
        eval(4'd0, 1'b0, "idle_ignore_row0");

        // Load 0x6800, with a stall in the middle
        start_load();
        send_bits(16'h6800, 6);
        finish_load(1'b1, "load6800");
        eval(4'b1011, 1'b1, "t6800_1011");
        eval(4'b1101, 1'b1, "t6800_1101");
        eval(4'b1110, 1'b1, "t6800_1110");
        eval(4'b1111, 1'b0, "t6800_1111");
        eval(4'b0000, 1'b0, "t6800_0000");

        // Live reload to 0xFFFF with row 15 evaluated every cycle
        in_vec   = 4'b1111;
        in_valid = 1'b1;
        start_load();
        check("reload_start_out", out, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
            check($sformatf("reload_out_bit%0d", i), out, 1'b0);
        end
`ifdef TT_LOAD_PARITY_EN
        cfg_bit = 1'b0;
        tick();
        check("reload_out_parity", out, 1'b0);
`endif
        cfg_valid = 1'b0;
        check("reload_done", cfg_done, 1'b1);
        check("reload_out_commit_edge", out, 1'b0);
        tick();
        check("reload_out_new", out, 1'b1);
        check("reload_done_pulse", cfg_done, 1'b0);

`ifdef TT_LOAD_PARITY_EN
        // Bad parity: rejected, previous table (0xFFFF) retained
        start_load();
        send_bits(16'h6800, -1);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b0;
        tick();
        cfg_valid = 1'b0;
        check("badpar_err", cfg_err, 1'b1);
        check("badpar_done", cfg_done, 1'b0);
        tick();
        check("badpar_err_pulse", cfg_err, 1'b0);
        eval(4'b1011, 1'b1, "badpar_keep_1011");
        eval(4'b0000, 1'b1, "badpar_keep_0000");
`endif

        // Restart after 7 bits; colliding start+valid drops that bit
        start_load();
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
        end
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("restart_ready", cfg_ready, 1'b1);
        check("restart_no_done", cfg_done, 1'b0);
        send_bits(16'h0001, -1);
        finish_load(1'b1, "load0001");
        eval(4'b0000, 1'b1, "t0001_0000");
        eval(4'b1011, 1'b0, "t0001_1011");
        eval(4'b0001, 1'b0, "t0001_0001");
        eval(4'b1111, 1'b0, "t0001_1111");

        // Reset in the middle of a load
        start_load();
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset_async");
        tick();
        check_all_zero("midreset_held");
        cfg_valid = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_ready", cfg_ready, 1'b0);
        for (int r = 0; r < 16; r++) eval(4'(r), 1'b0, $sformatf("post_reset_row%0d", r));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
